// File: rtl/chess_pkg.sv
// Shared definitions for the chess clock turn controller: state encoding and
// default widths.
package chess_pkg;

    typedef enum logic [2:0] {
        ST_SETUP = 3'd0,
        ST_RUN1  = 3'd1,
        ST_RUN2  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_FLAG  = 3'd4
    } state_e;

    localparam int unsigned MOVE_W_DEF  = 10;
    localparam int unsigned INC_W_DEF   = 6;
    localparam int unsigned INC_SEC_DEF = 5;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level: one-cycle event when the level
// is high and was low on the previous clock.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn;
        end
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock game sequencer: runs at most one player timer, latches time-out
// flags, counts full moves. Define FISCHER_INC_EN for per-move increment strobes.
module chess_turn_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned MOVE_W  = MOVE_W_DEF,
    parameter int unsigned INC_W   = INC_W_DEF,
    parameter int unsigned INC_SEC = INC_SEC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_p1,
    input  logic              btn_p2,
    input  logic              btn_pause,
    input  logic              btn_sel,
    input  logic              new_game,
    input  logic              p1_zero,
    input  logic              p2_zero,
    output logic              en1,
    output logic              en2,
    output logic              setup_on1,
    output logic              setup_on2,
    output logic              flag1,
    output logic              flag2,
    output logic [MOVE_W-1:0] move_cnt,
    output logic [2:0]        state_o,
    output logic              inc_req1,
    output logic              inc_req2,
    output logic [INC_W-1:0]  inc_val
);

    logic ev_p1, ev_p2, ev_pause, ev_sel;

    btn_edge u_edge_p1 (.clk(clk), .rst_n(rst_n), .btn(btn_p1), .rise(ev_p1));
    btn_edge u_edge_p2 (.clk(clk), .rst_n(rst_n), .btn(btn_p2), .rise(ev_p2));
    btn_edge u_edge_pause (.clk(clk), .rst_n(rst_n), .btn(btn_pause), .rise(ev_pause));
    btn_edge u_edge_sel (.clk(clk), .rst_n(rst_n), .btn(btn_sel), .rise(ev_sel));

    state_e            state_q, state_d;
    state_e            resume_q, resume_d;
    logic              sel_q, sel_d;
    logic              flag1_q, flag1_d;
    logic              flag2_q, flag2_d;
    logic [MOVE_W-1:0] cnt_q, cnt_d;
    logic              en1_q, en2_q, son1_q, son2_q;

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        sel_d    = sel_q;
        flag1_d  = flag1_q;
        flag2_d  = flag2_q;
        cnt_d    = cnt_q;
        if (new_game) begin
            state_d = ST_SETUP;
            sel_d   = 1'b0;
            flag1_d = 1'b0;
            flag2_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    if (ev_sel) sel_d = ~sel_q;
                    if (ev_p2) state_d = ST_RUN1;
                    else if (ev_p1) state_d = ST_RUN2;
                end
                // Own time-out outranks any button pressed in the same cycle.
                ST_RUN1: begin
                    if (p1_zero) begin
                        state_d = ST_FLAG;
                        flag1_d = 1'b1;
                    end else if (ev_p1) begin
                        state_d = ST_RUN2;
                    end else if (ev_pause) begin
                        state_d  = ST_PAUSE;
                        resume_d = ST_RUN1;
                    end
                end
                ST_RUN2: begin
                    if (p2_zero) begin
                        state_d = ST_FLAG;
                        flag2_d = 1'b1;
                    end else if (ev_p2) begin
                        state_d = ST_RUN1;
                        if (cnt_q != {MOVE_W{1'b1}}) cnt_d = cnt_q + MOVE_W'(1);
                    end else if (ev_pause) begin
                        state_d  = ST_PAUSE;
                        resume_d = ST_RUN2;
                    end
                end
                ST_PAUSE: begin
                    if (ev_pause) state_d = resume_q;
                end
                ST_FLAG: ;
                default: state_d = ST_SETUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SETUP;
            resume_q <= ST_RUN1;
            sel_q    <= 1'b0;
            flag1_q  <= 1'b0;
            flag2_q  <= 1'b0;
            cnt_q    <= '0;
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            son1_q   <= 1'b1;
            son2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            sel_q    <= sel_d;
            flag1_q  <= flag1_d;
            flag2_q  <= flag2_d;
            cnt_q    <= cnt_d;
            en1_q    <= (state_d == ST_RUN1);
            en2_q    <= (state_d == ST_RUN2);
            son1_q   <= (state_d == ST_SETUP) & ~sel_d;
            son2_q   <= (state_d == ST_SETUP) & sel_d;
        end
    end

    assign en1       = en1_q;
    assign en2       = en2_q;
    assign setup_on1 = son1_q;
    assign setup_on2 = son2_q;
    assign flag1     = flag1_q;
    assign flag2     = flag2_q;
    assign move_cnt  = cnt_q;
    assign state_o   = state_q;

`ifdef FISCHER_INC_EN
    logic inc1_q, inc2_q;

    // Strobe only on a genuine hand-over: time-out and new_game both suppress it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc1_q <= 1'b0;
            inc2_q <= 1'b0;
        end else begin
            inc1_q <= !new_game && (state_q == ST_RUN1) && !p1_zero && ev_p1;
            inc2_q <= !new_game && (state_q == ST_RUN2) && !p2_zero && ev_p2;
        end
    end

    assign inc_req1 = inc1_q;
    assign inc_req2 = inc2_q;
    assign inc_val  = INC_W'(INC_SEC);
`else
    assign inc_req1 = 1'b0;
    assign inc_req2 = 1'b0;
    assign inc_val  = '0;
`endif

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench for chess_turn_ctrl (built with MOVE_W=2 to reach saturation).
module tb_chess_turn_ctrl;

    localparam int unsigned MW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_p1 = 1'b0, btn_p2 = 1'b0, btn_pause = 1'b0, btn_sel = 1'b0;
    logic          new_game = 1'b0, p1_zero = 1'b0, p2_zero = 1'b0;
    logic          en1, en2, setup_on1, setup_on2, flag1, flag2, inc_req1, inc_req2;
    logic [MW-1:0] move_cnt;
    logic [2:0]    state_o;
    logic [5:0]    inc_val;

    chess_turn_ctrl #(.MOVE_W(MW), .INC_W(6), .INC_SEC(5)) dut (
        .clk(clk), .rst_n(rst_n), .btn_p1(btn_p1), .btn_p2(btn_p2),
        .btn_pause(btn_pause), .btn_sel(btn_sel), .new_game(new_game),
        .p1_zero(p1_zero), .p2_zero(p2_zero), .en1(en1), .en2(en2),
        .setup_on1(setup_on1), .setup_on2(setup_on2), .flag1(flag1), .flag2(flag2),
        .move_cnt(move_cnt), .state_o(state_o), .inc_req1(inc_req1),
        .inc_req2(inc_req2), .inc_val(inc_val)
    );

    always #5 clk = ~clk;

    // {state, en1, en2, son1, son2, flag1, flag2, inc1, inc2, move_cnt, inc_val}
    logic [18:0] obs;
    assign obs = {state_o, en1, en2, setup_on1, setup_on2, flag1, flag2,
                  inc_req1, inc_req2, move_cnt, inc_val};

    typedef struct {
        logic [6:0]  in;   // {p1, p2, pause, sel, new_game, p1_zero, p2_zero}
        logic [18:0] exp;
    } row_t;

    logic [18:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [18:0] mk(input logic [2:0] st, input logic sel,
                                       input logic f1, input logic f2,
                                       input logic i1, input logic i2,
                                       input logic [1:0] cnt);
        logic [5:0] iv;
`ifdef FISCHER_INC_EN
        iv = 6'd5;
`else
        i1 = 1'b0;
        i2 = 1'b0;
        iv = 6'd0;
`endif
        return {st, st == 3'd1, st == 3'd2, st == 3'd0 && !sel, st == 3'd0 && sel,
                f1, f2, i1, i2, cnt, iv};
    endfunction

    function automatic row_t r(input logic [6:0] in, input logic [2:0] st,
                               input logic sel, input logic f1, input logic f2,
                               input logic i1, input logic i2, input logic [1:0] cnt);
        row_t x;
        x.in  = in;
        x.exp = mk(st, sel, f1, f2, i1, i2, cnt);
        return x;
    endfunction

    // Apply a row at the falling edge, queue its expectation, land on the next falling edge.
    task automatic drive(input row_t x);
        {btn_p1, btn_p2, btn_pause, btn_sel, new_game, p1_zero, p2_zero} = x.in;
        sb.push_back(x.exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] want;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        @(negedge clk);
        want = sb.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, want);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_setup_sel();
        row_t rows[$];
        logic [18:0] want;
        rows.push_back(r(7'b0001000, 3'd0, 1, 0, 0, 0, 0, 2'd0));
        for (int k = 0; k < 50; k++) rows.push_back(r(7'b0001000, 3'd0, 1, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd0, 1, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0010000, 3'd0, 1, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0001000, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL setup_sel[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_moves();
        row_t rows[$];
        logic [18:0] want;
        rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b1000000, 3'd2, 0, 0, 0, 1, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd2, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 1, 2'd1));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b1000000, 3'd2, 0, 0, 0, 1, 0, 2'd1));
        rows.push_back(r(7'b0000000, 3'd2, 0, 0, 0, 0, 0, 2'd1));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL moves[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_pause();
        row_t rows[$];
        logic [18:0] want;
        rows.push_back(r(7'b0010000, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0000000, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b1000000, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0000000, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0100000, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0000001, 3'd3, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0010000, 3'd2, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0000000, 3'd2, 0, 0, 0, 0, 0, 2'd1));
        rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 1, 2'd2));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0010000, 3'd3, 0, 0, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0000000, 3'd3, 0, 0, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0010000, 3'd1, 0, 0, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd2));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL pause[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_flag();
        row_t rows[$];
        logic [18:0] want;
        rows.push_back(r(7'b1000011, 3'd4, 0, 1, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0000000, 3'd4, 0, 1, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b1111000, 3'd4, 0, 1, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0000000, 3'd4, 0, 1, 0, 0, 0, 2'd2));
        rows.push_back(r(7'b0000100, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0100100, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b1000000, 3'd2, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd2, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000011, 3'd4, 0, 0, 1, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd4, 0, 0, 1, 0, 0, 2'd0));
        rows.push_back(r(7'b0000100, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b1000100, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL flag[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        logic [18:0] want;
        logic [1:0] c;
        rows.push_back(r(7'b1100000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        c = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            rows.push_back(r(7'b1000000, 3'd2, 0, 0, 0, 1, 0, c));
            rows.push_back(r(7'b0000000, 3'd2, 0, 0, 0, 0, 0, c));
            c = (k < 3) ? 2'(k) : 2'd3;
            rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 1, c));
            rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, c));
        end
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL saturate[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        logic [18:0] want;
        drive(r(7'b1000000, 3'd2, 0, 0, 0, 1, 0, 2'd3));
        want = sb.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL async_pre: got %h want %h", obs, want);
        end
        // Drop reset mid-cycle with btn_p1 still held: outputs must clear with no clock.
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(mk(3'd0, 0, 0, 0, 0, 0, 2'd0));
        want = sb.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL async_now: got %h want %h", obs, want);
        end
        @(negedge clk);
        sb.push_back(mk(3'd0, 0, 0, 0, 0, 0, 2'd0));
        want = sb.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL async_hold: got %h want %h", obs, want);
        end
        rst_n = 1'b1;
        rows.push_back(r(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0100000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        rows.push_back(r(7'b0000000, 3'd1, 0, 0, 0, 0, 0, 2'd0));
        foreach (rows[i]) begin
            drive(rows[i]);
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL async_after[%0d]: got %h want %h", i, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_setup_sel();
        test_moves();
        test_pause();
        test_flag();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chess_turn_ctrl.md
Name: chess_turn_ctrl

Overview:
Game-sequencing controller that sits between the debounced player/control buttons and the two per-player countdown timers of the chess clock.
- Owns the game state machine and drives the timer count enables, so at most one clock runs at a time.
- Selects which timer the shared set-up buttons edit.
- Latches time-out flags and counts full moves.
- Optionally issues a Fischer increment to the player who just moved.

Parameters:
MOVE_W, 10, width of full-move counter (saturates at 2^MOVE_W-1)
INC_W, 6, width of increment value
INC_SEC, 5, seconds added per completed move (FISCHER_INC_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_p1  in  1  player 1 move-done button, debounced level
btn_p2  in  1  player 2 move-done button, debounced level
btn_pause  in  1  pause/resume toggle, debounced level
btn_sel  in  1  set-up target toggle, debounced level
new_game  in  1  return to SETUP, clear counters/flags, level (acts while high)
p1_zero  in  1  player 1 timer reads 00:00
p2_zero  in  1  player 2 timer reads 00:00
en1  out  1  player 1 timer count enable
en2  out  1  player 2 timer count enable
setup_on1  out  1  player 1 timer accepts set-up buttons
setup_on2  out  1  player 2 timer accepts set-up buttons
flag1  out  1  player 1 lost on time
flag2  out  1  player 2 lost on time
move_cnt  out  MOVE_W  completed full moves
state_o  out  3  encoded state, for LEDs/debug
inc_req1  out  1  one-cycle add-increment strobe to timer 1
inc_req2  out  1  one-cycle add-increment strobe to timer 2
inc_val  out  INC_W  increment seconds, constant INC_SEC

Behaviour:
- Reset values: state SETUP, setup_sel=0, en1=en2=0, setup_on1=1, setup_on2=0, flags 0, move_cnt 0, inc_req* 0.
- All outputs are registered or decoded from registered state.
- Edge detect: each btn_* has a prev register, cleared on reset. An event is btn=1 while prev=0. The state update happens on that same clk edge, so en*/flags change one cycle after the button is sampled high. A held button gives exactly one event.
- States: SETUP=0, RUN1=1, RUN2=2, PAUSE=3, FLAG=4. Other codes go to SETUP.
- SETUP:
  - en1=en2=0.
  - A btn_sel event toggles setup_sel; setup_on1=~setup_sel, setup_on2=setup_sel. In all other states both setup_on are 0.
  - btn_p2 event -> RUN1 (player 1 moves first).
  - btn_p1 event -> RUN2.
  - Both in the same cycle -> RUN1.
  - btn_pause is ignored.
- RUN1:
  - en1=1.
  - p1_zero=1 -> FLAG with flag1=1. This has priority over every button in the same cycle.
  - Otherwise a btn_p1 event -> RUN2, with inc_req1 pulse.
  - Otherwise a btn_pause event -> PAUSE, resume_st=RUN1.
  - btn_p2 is ignored.
- RUN2: mirror of RUN1 (en2, p2_zero/flag2, btn_p1 ignored). On a btn_p2 event -> RUN1, move_cnt increments (saturating), inc_req2 pulse.
- PAUSE:
  - en1=en2=0.
  - A btn_pause event returns to resume_st.
  - Player buttons are ignored. A zero input is not re-checked until resumed.
- FLAG: en1=en2=0. Flags hold. Every button is ignored.
- new_game=1 in any state: next state SETUP, flags/move_cnt cleared, setup_sel=0. Takes priority over all events in that cycle.
- Async rst_n mid-game: immediate reset values, no strobes emitted.
- Simultaneous p1_zero and p2_zero in one state: only the running player's flag is set.

Optional Feature:
- Macro FISCHER_INC_EN.
- Defined: inc_req1/inc_req2 pulse exactly one cycle on the move-completing transition, and inc_val=INC_SEC. No pulse is issued when the same cycle goes to FLAG or is overridden by new_game.
- Undefined: inc_req1=inc_req2=0 and inc_val=0 constantly; no increment logic is synthesized. All other behaviour is identical.

Decomposition:
- Shared package chess_pkg: state encoding constants (ST_SETUP..ST_FLAG, 3 bits), default MOVE_W/INC_W.
- Sub-module btn_edge (registered rising-edge detector with async active-low reset), instantiated four times.
- FSM and counters stay in chess_turn_ctrl.

Test Plan:
1. Reset -> en1=en2=0, setup_on1=1, state_o=0. btn_sel pulse -> setup_on2=1, setup_on1=0 one cycle later. Held btn_sel for 50 cycles -> single toggle only.
2. SETUP, btn_p2 press -> RUN1, en1=1. btn_p1 -> RUN2, inc_req1 one cycle (FISCHER_INC_EN, inc_val=5). btn_p2 -> RUN1, move_cnt=1, inc_req2 pulse.
3. RUN2, btn_pause -> PAUSE, en2=0. btn_p1/btn_p2 presses -> no change. btn_pause -> RUN2, en2=1.
4. RUN1, p1_zero=1 and btn_p1 event in the same cycle -> FLAG, flag1=1, en1=0, no inc_req1. Further buttons -> no change. new_game=1 -> SETUP, flag1=0, move_cnt=0.
5. MOVE_W=2, 5 full moves -> move_cnt saturates at 3.
6. rst_n low in RUN2 after 2 moves -> all outputs reset immediately, asynchronously. After release -> SETUP.
